// File: rtl/mem_access_unit_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared types and constants for the MEM-stage bus master:
//   - chip-enable encodings of the membus
//   - mem_op_t load/store opcode (3 bits)
//   - mau_state_t controller states
//   - byte-lane select constants
//   - helpers to classify an opcode and detect misalignment
// ----------------------------------------------------------------------------
package mem_access_unit_pkg;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam logic [3:0] SEL_NONE    = 4'b0000;
    localparam logic [3:0] SEL_ALL     = 4'b1111;
    localparam logic [3:0] SEL_LO_HALF = 4'b0011;
    localparam logic [3:0] SEL_HI_HALF = 4'b1100;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        RESP   = 3'd4
    } mau_state_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_subword_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lo);
        logic mis;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = lo[0];
            OP_LW, OP_SW:         mis = (lo != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ----------------------------------------------------------------------------
// i_membus
// Word-wide RAM bus. The master drives ce/we/addr/write/sel; the RAM returns
// read combinationally for the presented address. The RAM writes all four
// byte lanes whenever ce and we are set, regardless of sel.
// ----------------------------------------------------------------------------
interface i_membus;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] write;
    logic [3:0]  sel;
    logic [31:0] read;

    modport master (output ce, output we, output addr, output write, output sel, input read);
    modport slave  (input ce, input we, input addr, input write, input sel, output read);
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// ----------------------------------------------------------------------------
// mem_lane_align (combinational)
// Byte-lane handling keyed by opcode and address bits [1:0], little-endian
// (lane 0 = bits 7:0).
//   op_i, addr_lo_i : latched opcode and low address bits
//   rdata_i         : word read from RAM          -> load_o (extracted/extended)
//   merge_i         : word captured in RMW read   -> merged_o (lanes replaced)
//   wdata_i         : right-aligned store data    -> repl_o/repl_sel_o
//                                                   (replicated, single-cycle)
// ----------------------------------------------------------------------------
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] merge_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o,
    output logic [31:0] repl_o,
    output logic [3:0]  repl_sel_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Load lane extraction and sign/zero extension.
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            2'd3:    byte_s = rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (op_i)
            OP_LB:   load_o = {{24{byte_s[7]}}, byte_s};
            OP_LBU:  load_o = {24'h000000, byte_s};
            OP_LH:   load_o = {{16{half_s[15]}}, half_s};
            OP_LHU:  load_o = {16'h0000, half_s};
            OP_LW:   load_o = rdata_i;
            default: load_o = 32'h0000_0000;
        endcase
    end

    // Read-merge: overwrite only the target lanes of the captured word.
    always_comb begin
        merged_o = merge_i;
        case (op_i)
            OP_SB: begin
                case (addr_lo_i)
                    2'd0:    merged_o[7:0]   = wdata_i[7:0];
                    2'd1:    merged_o[15:8]  = wdata_i[7:0];
                    2'd2:    merged_o[23:16] = wdata_i[7:0];
                    2'd3:    merged_o[31:24] = wdata_i[7:0];
                    default: merged_o = merge_i;
                endcase
            end
            OP_SH: begin
                if (addr_lo_i[1]) begin
                    merged_o[31:16] = wdata_i[15:0];
                end else begin
                    merged_o[15:0] = wdata_i[15:0];
                end
            end
            OP_SW:   merged_o = wdata_i;
            default: merged_o = merge_i;
        endcase
    end

    // Single-cycle sub-word store: replicate data, select lanes via sel.
    always_comb begin
        case (op_i)
            OP_SB: begin
                repl_o     = {4{wdata_i[7:0]}};
                repl_sel_o = 4'b0001 << addr_lo_i;
            end
            OP_SH: begin
                repl_o     = {2{wdata_i[15:0]}};
                repl_sel_o = addr_lo_i[1] ? SEL_HI_HALF : SEL_LO_HALF;
            end
            default: begin
                repl_o     = wdata_i;
                repl_sel_o = SEL_ALL;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage bus master: accepts one load/store at a time, runs the membus
// cycle(s) and returns a one-cycle response. Sub-word stores are done as a
// read-merge-write of the full word when RMW_ENABLE=1.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   req_*           : request handshake (valid/ready, op, addr, wdata)
//   resp_*          : completion pulse, load data, misalignment error+addr
//   ram             : i_membus master
// ----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter bit          RMW_ENABLE = 1'b1,
    parameter logic [31:0] ADDR_MASK  = 32'h0007_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  mem_op_t     req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] resp_badaddr,
    i_membus.master     ram
);

    mau_state_t  state_q;
    mem_op_t     op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic [31:0] resp_badaddr_q;

    logic [31:0] load_s;
    logic [31:0] merged_s;
    logic [31:0] repl_s;
    logic [3:0]  repl_sel_s;

    mem_lane_align u_lane (
        .op_i       (op_q),
        .addr_lo_i  (addr_q[1:0]),
        .rdata_i    (ram.read),
        .merge_i    (merge_q),
        .wdata_i    (wdata_q),
        .load_o     (load_s),
        .merged_o   (merged_s),
        .repl_o     (repl_s),
        .repl_sel_o (repl_sel_s)
    );

    assign req_ready    = (state_q == IDLE) & rst;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;
    assign resp_badaddr = resp_badaddr_q;

    // Controller FSM, request latches and registered response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            op_q           <= OP_LB;
            addr_q         <= 32'h0000_0000;
            wdata_q        <= 32'h0000_0000;
            merge_q        <= 32'h0000_0000;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 32'h0000_0000;
            resp_err_q     <= 1'b0;
            resp_badaddr_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (is_misaligned(req_op, req_addr[1:0])) begin
                            // No bus cycle: report straight away.
                            state_q        <= RESP;
                            resp_valid_q   <= 1'b1;
                            resp_err_q     <= 1'b1;
                            resp_badaddr_q <= req_addr;
                        end else if (RMW_ENABLE && is_subword_store(req_op)) begin
                            state_q <= RMW_RD;
                        end else begin
                            state_q <= ACCESS;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!is_store(op_q)) begin
                        resp_rdata_q <= load_s;
                    end else begin
                        resp_rdata_q <= 32'h0000_0000;
                    end
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RMW_RD: begin
                    merge_q <= ram.read;
                    state_q <= RMW_WR;
                end
                RMW_WR: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    resp_valid_q   <= 1'b0;
                    resp_rdata_q   <= 32'h0000_0000;
                    resp_err_q     <= 1'b0;
                    resp_badaddr_q <= 32'h0000_0000;
                    state_q        <= IDLE;
                end
                default: begin
                    resp_valid_q   <= 1'b0;
                    resp_rdata_q   <= 32'h0000_0000;
                    resp_err_q     <= 1'b0;
                    resp_badaddr_q <= 32'h0000_0000;
                    state_q        <= IDLE;
                end
            endcase
        end
    end

    // Moore bus drive from state and latched request; forced idle in reset
    // so no write can reach the RAM during the reset cycle.
    always_comb begin
        ram.ce    = CHIP_DISABLE;
        ram.we    = 1'b0;
        ram.addr  = 32'h0000_0000;
        ram.write = 32'h0000_0000;
        ram.sel   = SEL_NONE;
        if (rst) begin
            case (state_q)
                ACCESS: begin
                    ram.ce   = CHIP_ENABLE;
                    ram.addr = addr_q & ADDR_MASK;
                    if (is_store(op_q)) begin
                        ram.we    = 1'b1;
                        ram.write = repl_s;
                        ram.sel   = repl_sel_s;
                    end else begin
                        ram.we = 1'b0;
                    end
                end
                RMW_RD: begin
                    ram.ce   = CHIP_ENABLE;
                    ram.addr = addr_q & ADDR_MASK;
                end
                RMW_WR: begin
                    ram.ce    = CHIP_ENABLE;
                    ram.we    = 1'b1;
                    ram.addr  = addr_q & ADDR_MASK;
                    ram.write = merged_s;
                    ram.sel   = SEL_ALL;
                end
                default: begin
                    ram.ce = CHIP_DISABLE;
                end
            endcase
        end else begin
            ram.ce = CHIP_DISABLE;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
// Drives mem_access_unit against a behavioural RAM on i_membus and checks
// every response and bus write against a word-array reference model.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    mem_op_t     req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] resp_badaddr;

    i_membus bus ();

    mem_access_unit #(
        .RMW_ENABLE (1'b1),
        .ADDR_MASK  (32'h0007_FFFC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .resp_badaddr (resp_badaddr),
        .ram          (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] ram_mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    int acc_count = 0;
    int resp_count = 0;

    // Behavioural RAM: combinational read, full-word write on ce&we.
    assign bus.read = ram_mem[bus.addr[11:2]];

    always @(posedge clk) begin
        if (bus.ce === CHIP_ENABLE && bus.we === 1'b1) begin
            ram_mem[bus.addr[11:2]] <= bus.write;
            wr_count <= wr_count + 1;
        end
        if (req_ready === 1'b1 && req_valid === 1'b1) acc_count <= acc_count + 1;
        if (resp_valid === 1'b1) resp_count <= resp_count + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_mis(mem_op_t op, logic [31:0] a);
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return (a % 2) != 0;
        if (op == OP_LW || op == OP_SW) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(mem_op_t op, logic [31:0] word, logic [31:0] a);
        int sh;
        logic [31:0] v, b, h;
        sh = 8 * int'(a % 4);
        v = word >> sh;
        b = v & 32'hFF;
        h = v & 32'hFFFF;
        case (op)
            OP_LB:   return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            OP_LHU:  return h;
            OP_LW:   return word;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(mem_op_t op, logic [31:0] word,
                                              logic [31:0] a, logic [31:0] wd);
        int sh;
        logic [31:0] m;
        sh = 8 * int'(a % 4);
        case (op)
            OP_SW:   return wd;
            OP_SB: begin m = 32'hFF << sh;   return (word & ~m) | ((wd & 32'hFF) << sh); end
            OP_SH: begin m = 32'hFFFF << sh; return (word & ~m) | ((wd & 32'hFFFF) << sh); end
            default: return word;
        endcase
    endfunction

    // Issue one request and check response, latency, bus activity and memory.
    task automatic run_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit hold, output logic [31:0] got_rdata);
        int idx, lat_seen, wr_k, exp_lat;
        bit seen_ce, got_wr, mis, st;
        logic [31:0] wr_data, exp_word, exp_rd;
        logic [3:0] wr_sel;
        string t;
        t = $sformatf("%s@%0h", op.name(), addr);
        idx = int'(addr[11:2]);
        mis = ref_mis(op, addr);
        st = (op == OP_SB || op == OP_SH || op == OP_SW);
        exp_lat = mis ? 1 : ((op == OP_SB || op == OP_SH) ? 3 : 2);
        exp_rd = (mis || st) ? 32'h0 : ref_load(op, ref_mem[idx], addr);
        exp_word = (st && !mis) ? ref_store(op, ref_mem[idx], addr, wdata) : ref_mem[idx];
        seen_ce = 1'b0; got_wr = 1'b0; wr_k = 0; lat_seen = 0;
        wr_data = 32'h0; wr_sel = 4'h0; got_rdata = 32'h0;

        req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        for (int w = 0; w < 8 && req_ready !== 1'b1; w++) @(negedge clk);
        check_eq({t, " ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) req_valid = 1'b0;
            if (bus.ce === CHIP_ENABLE) seen_ce = 1'b1;
            if (bus.ce === CHIP_ENABLE && bus.we === 1'b1) begin
                got_wr = 1'b1; wr_k = k; wr_data = bus.write; wr_sel = bus.sel;
            end
            if (resp_valid === 1'b1) begin
                lat_seen = k;
                got_rdata = resp_rdata;
                check_eq({t, " rdata"}, resp_rdata, exp_rd);
                check_eq({t, " err"}, 32'(resp_err), 32'(mis));
                check_eq({t, " badaddr"}, resp_badaddr, mis ? addr : 32'h0);
                break;
            end
        end
        check_eq({t, " latency"}, 32'(lat_seen), 32'(exp_lat));
        check_eq({t, " ce_used"}, 32'(seen_ce), 32'(!mis));
        check_eq({t, " wrote"}, 32'(got_wr), 32'(st && !mis));
        if (st && !mis) begin
            check_eq({t, " wr_cycle"}, 32'(wr_k), (op == OP_SW) ? 32'd1 : 32'd2);
            check_eq({t, " wr_data"}, wr_data, exp_word);
            check_eq({t, " wr_sel"}, 32'(wr_sel), 32'hF);
        end
        ref_mem[idx] = exp_word;
        @(negedge clk);
        check_eq({t, " resp_clear"}, {resp_rdata[30:0], resp_valid}, 32'h0);
        check_eq({t, " err_clear"}, 32'(resp_err), 32'h0);
        check_eq({t, " mem"}, ram_mem[idx], ref_mem[idx]);
    endtask

    logic [31:0] rd;
    int acc0, resp0, wr0;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = $urandom;
            ref_mem[i] = ram_mem[i];
        end
        rst = 1'b0; req_valid = 1'b0; req_op = OP_LB; req_addr = 32'h0; req_wdata = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst ready", 32'(req_ready), 32'h0);
        check_eq("rst resp_valid", 32'(resp_valid), 32'h0);
        check_eq("rst rdata", resp_rdata, 32'h0);
        check_eq("rst err", 32'(resp_err), 32'h0);
        check_eq("rst badaddr", resp_badaddr, 32'h0);
        check_eq("rst ce", 32'(bus.ce), 32'(CHIP_DISABLE));
        check_eq("rst bus", bus.addr | bus.write | 32'(bus.sel) | 32'(bus.we), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("post-rst ready", 32'(req_ready), 32'h1);

        // Directed function tests
        run_op(OP_SW,  32'h100, 32'hDEADBEEF, 1'b0, rd);
        run_op(OP_LW,  32'h100, 32'h0, 1'b0, rd); check_eq("LW 0x100 const", rd, 32'hDEADBEEF);
        run_op(OP_LB,  32'h101, 32'h0, 1'b0, rd); check_eq("LB 0x101 const", rd, 32'hFFFFFFBE);
        run_op(OP_LBU, 32'h101, 32'h0, 1'b0, rd); check_eq("LBU 0x101 const", rd, 32'h000000BE);
        run_op(OP_LH,  32'h102, 32'h0, 1'b0, rd); check_eq("LH 0x102 const", rd, 32'hFFFFDEAD);
        run_op(OP_LHU, 32'h100, 32'h0, 1'b0, rd); check_eq("LHU 0x100 const", rd, 32'h0000BEEF);
        run_op(OP_SB,  32'h102, 32'h55, 1'b0, rd);
        run_op(OP_LW,  32'h100, 32'h0, 1'b0, rd); check_eq("LW after SB const", rd, 32'hDE55BEEF);
        run_op(OP_LW,  32'h103, 32'h0, 1'b0, rd);
        run_op(OP_SH,  32'h101, 32'h1234, 1'b0, rd);
        check_eq("mem 0x100 unchanged", ram_mem[32'h100 >> 2], 32'hDE55BEEF);

        // Reset in the middle of an SB read-merge-write
        req_op = OP_SB; req_addr = 32'h202; req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid-rmw ce", 32'(bus.ce), 32'(CHIP_ENABLE));
        rst = 1'b0; req_valid = 1'b0;
        wr0 = wr_count;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("abort ce", 32'(bus.ce), 32'(CHIP_DISABLE));
            check_eq("abort we", 32'(bus.we), 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort ready", 32'(req_ready), 32'h1);
        check_eq("abort resp_valid", 32'(resp_valid), 32'h0);
        check_eq("abort no write", 32'(wr_count - wr0), 32'h0);
        check_eq("abort mem", ram_mem[32'h202 >> 2], ref_mem[32'h202 >> 2]);

        // Back-to-back stream with req_valid held high
        acc0 = acc_count; resp0 = resp_count; wr0 = wr_count;
        run_op(OP_SW, 32'h140, 32'hA5A5_1234, 1'b1, rd);
        run_op(OP_LW, 32'h140, 32'h0, 1'b1, rd);
        run_op(OP_SB, 32'h141, 32'h77, 1'b1, rd);
        run_op(OP_LW, 32'h140, 32'h0, 1'b1, rd);
        run_op(OP_SH, 32'h142, 32'hBEEF, 1'b1, rd);
        run_op(OP_SW, 32'h144, 32'h0BAD_F00D, 1'b1, rd);
        run_op(OP_LW, 32'h144, 32'h0, 1'b1, rd);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b accepts", 32'(acc_count - acc0), 32'd7);
        check_eq("b2b responses", 32'(resp_count - resp0), 32'd7);
        check_eq("b2b writes", 32'(wr_count - wr0), 32'd4);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            run_op(mem_op_t'($urandom_range(0, 7)), 32'h300 + 32'($urandom_range(0, 63)),
                   $urandom, 1'($urandom_range(0, 1)), rd);
        end
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 32'h300 >> 2; i < (32'h340 >> 2); i++) begin
            check_eq($sformatf("final mem[%0d]", i), ram_mem[i], ref_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
